alu_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares the single combinational ALU between two requesters, for example the integer pipeline and a debug/microcode port. It accepts one operation at a time through a valid/ready handshake and picks between simultaneous requests round-robin. It drives the ALU from registered operands, captures the result, and returns it to the owning requester with backpressure. The ALU is instantiated beside this block: its opc/op1/op2 come from this block's alu_* outputs, and its res feeds alu_res.

---
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each operation passes through IDLE (grant and latch), EXEC (capture the result) and RESP (return it).
//
// Handshakes: a request moves on a clock edge where reqN_valid && reqN_ready.
// A response moves on a clock edge where rspN_valid && rspN_ready.
// reqN_ready is combinational from the valids and last_q, and is only high in IDLE.
// rspN_valid is only high in RESP, and only for the owning port.
// A request that is dropped before it is granted latches nothing.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPC_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPC_W-1:0] req0_opc,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPC_W-1:0] req1_opc,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_res,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_res,
    output logic [OPC_W-1:0] alu_opc,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_res,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt0, gnt1, rsp_hs;

    // On a tie, the requester that was not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state_q == IDLE) begin
            gnt0 = req0_valid && (!req1_valid || last_q);
            gnt1 = req1_valid && (!req0_valid || !last_q);
        end
    end

    assign rsp_hs = (state_q == RESP) && (owner_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        opc_d   = opc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    owner_d = gnt1;
                    opc_d   = gnt1 ? req1_opc : req0_opc;
                    op1_d   = gnt1 ? req1_op1 : req0_op1;
                    op2_d   = gnt1 ? req1_op2 : req0_op2;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = alu_res;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    last_d  = owner_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            opc_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            opc_q   <= opc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp0_valid = (state_q == RESP) && !owner_q;
    assign rsp1_valid = (state_q == RESP) && owner_q;
    assign rsp0_res   = res_q;
    assign rsp1_res   = res_q;
    assign alu_opc    = opc_q;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model is checked on every negedge, and literal checks pin that model.
// A second instance with a 2-bit counter shares the same stimulus and covers counter wrap-around.
module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPC_W = 5;
    localparam int CNT_W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [OPC_W-1:0] req0_opc = '0, req1_opc = '0;
    logic [WIDTH-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
    logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;

    wire              req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
    wire  [WIDTH-1:0] rsp0_res, rsp1_res, alu_op1, alu_op2;
    wire  [OPC_W-1:0] alu_opc;
    wire  [CNT_W-1:0] op_count;
    wire  [1:0]       dbg_state;
    logic [WIDTH-1:0] alu_res;

    wire              w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_busy;
    wire  [WIDTH-1:0] w_rsp0_res, w_rsp1_res, w_alu_op1, w_alu_op2;
    wire  [OPC_W-1:0] w_alu_opc;
    wire  [1:0]       w_op_count;
    wire  [1:0]       w_dbg_state;
    logic [WIDTH-1:0] w_alu_res;

    // The ALU that sits beside the arbiter: {funct7 bits, funct3} encoding.
    function automatic logic [WIDTH-1:0] alu_fn(input logic [OPC_W-1:0] opc,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] prod;
        prod = a * b;
        case (opc)
            5'b00000: return a + b;
            5'b10000: return a - b;
            5'b00001: return a << b[4:0];
            5'b00100: return a ^ b;
            5'b00101: return a >> b[4:0];
            5'b00110: return a | b;
            5'b00111: return a & b;
            5'b01000: return prod[WIDTH-1:0];
            default:  return '0;
        endcase
    endfunction

    assign alu_res   = alu_fn(alu_opc, alu_op1, alu_op2);
    assign w_alu_res = alu_fn(w_alu_opc, w_alu_op1, w_alu_op2);

    alu_arbiter #(.WIDTH(WIDTH), .OPC_W(OPC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opc(req0_opc),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opc(req1_opc),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(rsp0_res),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(rsp1_res),
        .alu_opc(alu_opc), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_res(alu_res),
        .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
    );

    alu_arbiter #(.WIDTH(WIDTH), .OPC_W(OPC_W), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(w_req0_ready), .req0_opc(req0_opc),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(w_req1_ready), .req1_opc(req1_opc),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp0_valid(w_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_res(w_rsp0_res),
        .rsp1_valid(w_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_res(w_rsp1_res),
        .alu_opc(w_alu_opc), .alu_op1(w_alu_op1), .alu_op2(w_alu_op2), .alu_res(w_alu_res),
        .busy(w_busy), .op_count(w_op_count), .dbg_state(w_dbg_state)
    );

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding transaction with its age in cycles since the grant.
    bit               m_busy  = 1'b0;
    bit               m_owner = 1'b0;
    bit               m_last  = 1'b1;
    int               m_age   = 0;
    int unsigned      m_count = 0;
    logic [OPC_W-1:0] m_opc   = '0;
    logic [WIDTH-1:0] m_op1   = '0, m_op2 = '0, m_res = '0, m_resq = '0;
    logic [WIDTH-1:0] exp_q[$];

    always @(negedge clk) begin : compare
        bit e_r0, e_r1, e_v0, e_v1;
        logic [WIDTH-1:0] exp_res;
        if (!rst_n) begin
            check("rst_req0_ready", req0_ready, 0);
            check("rst_req1_ready", req1_ready, 0);
            check("rst_rsp0_valid", rsp0_valid, 0);
            check("rst_rsp1_valid", rsp1_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_op_count", op_count, 0);
            check("rst_res", rsp0_res, 0);
            check("rst_alu_op1", alu_op1, 0);
            m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_age = 0; m_count = 0;
            m_opc = '0; m_op1 = '0; m_op2 = '0; m_res = '0; m_resq = '0;
            exp_q.delete();
        end else begin
            e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
            e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
            e_v0 = m_busy && m_age == 1 && !m_owner;
            e_v1 = m_busy && m_age == 1 && m_owner;
            check("req0_ready", req0_ready, e_r0);
            check("req1_ready", req1_ready, e_r1);
            check("rsp0_valid", rsp0_valid, e_v0);
            check("rsp1_valid", rsp1_valid, e_v1);
            check("busy", busy, m_busy);
            check("op_count", op_count, m_count % 65536);
            check("w_op_count", w_op_count, m_count % 4);
            check("alu_opc", alu_opc, m_opc);
            check("alu_op1", alu_op1, m_op1);
            check("alu_op2", alu_op2, m_op2);
            check("rsp0_res", rsp0_res, m_resq);
            check("rsp1_res", rsp1_res, m_resq);
            if (!m_busy) begin
                if (e_r0 || e_r1) begin
                    m_busy  = 1'b1;
                    m_owner = e_r1;
                    m_age   = 0;
                    m_opc   = e_r1 ? req1_opc : req0_opc;
                    m_op1   = e_r1 ? req1_op1 : req0_op1;
                    m_op2   = e_r1 ? req1_op2 : req0_op2;
                    m_res   = alu_fn(m_opc, m_op1, m_op2);
                    exp_q.push_back(m_res);
                end
            end else if (m_age == 0) begin
                m_age  = 1;
                m_resq = m_res;
            end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                if (exp_q.size() > 0) begin
                    exp_res = exp_q.pop_front();
                    check("handshake_res", m_owner ? rsp1_res : rsp0_res, exp_res);
                end
                m_last  = m_owner;
                m_count = m_count + 1;
                m_busy  = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [OPC_W-1:0] opc,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (p == 0) begin
            req0_valid = 1'b1; req0_opc = opc; req0_op1 = a; req0_op2 = b;
        end else begin
            req1_valid = 1'b1; req1_opc = opc; req1_op1 = a; req1_op2 = b;
        end
    endtask

    task automatic do_reset();
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Leaves the caller at a negedge where the port's rsp_valid is high.
    task automatic wait_rsp(input int p, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles && !ok; i++) begin
            @(negedge clk);
            if (p == 0 ? rsp0_valid : rsp1_valid) ok = 1'b1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL wait_rsp%0d: no response within %0d cycles", p, max_cycles);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin : stimulus
        bit ok;
        bit got;
        do_reset();

        // Single op on port 0: 10 - 3.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b0;
        tick();
        set_req(0, 5'b10000, 32'd10, 32'd3);
        @(negedge clk);
        check("t1_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("t1_exec_rsp0_valid", rsp0_valid, 0);
        check("t1_exec_req0_ready", req0_ready, 0);
        @(negedge clk);
        check("t1_rsp0_valid", rsp0_valid, 1);
        check("t1_rsp0_res", rsp0_res, 7);
        check("t1_rsp1_valid", rsp1_valid, 0);
        @(negedge clk);
        check("t1_op_count", op_count, 1);
        check("t1_idle", busy, 0);

        // Tie and fairness: both ports always valid.
        do_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        set_req(0, 5'b01000, 32'd6, 32'd7);
        set_req(1, 5'b00111, 32'h0000_00F0, 32'h0000_003C);
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                if (rsp0_valid || rsp1_valid) got = 1'b1;
            end
            if (got) begin
                check("t2_port", rsp1_valid, k % 2);
                check("t2_res", (k % 2 == 1) ? rsp1_res : rsp0_res, (k % 2 == 1) ? 32'h30 : 32'd42);
            end else begin
                tests++;
                fails++;
                $display("FAIL t2_timeout: response %0d missing", k);
            end
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("t2_op_count", op_count, 4);

        // Backpressure on port 1 while port 0 waits.
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b0;
        tick();
        set_req(1, 5'b00001, 32'd1, 32'd4);
        @(negedge clk);
        check("t3_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        set_req(0, 5'b00000, 32'd5, 32'd5);
        @(negedge clk);
        check("t3_exec_req0_ready", req0_ready, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", rsp1_valid, 1);
            check("t3_hold_res", rsp1_res, 16);
            check("t3_hold_req0_ready", req0_ready, 0);
        end
        tick();
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("t3_valid_before_hs", rsp1_valid, 1);
        tick();
        rsp1_ready = 1'b0;
        @(negedge clk);
        check("t3_req0_granted", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        wait_rsp(0, 4, ok);
        if (ok) check("t3_rsp0_res", rsp0_res, 10);
        @(negedge clk);
        check("t3_op_count", op_count, 6);

        // Reset during EXEC of 5 + 5.
        tick();
        set_req(0, 5'b00000, 32'd5, 32'd5);
        @(negedge clk);
        check("t4_req0_ready", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_busy", busy, 0);
        check("t4_op_count", op_count, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_no_rsp", rsp0_valid, 0);
        end
        tick();
        set_req(0, 5'b00000, 32'd5, 32'd5);
        set_req(1, 5'b00100, 32'hFF, 32'h0F);
        @(negedge clk);
        check("t4_tie_req0", req0_ready, 1);
        check("t4_tie_req1", req1_ready, 0);

        // Abandoned request: port 1 stays valid one busy cycle, then drops.
        tick();
        req0_valid = 1'b0;
        tick();
        req1_valid = 1'b0;
        wait_rsp(0, 4, ok);
        if (ok) check("t5_rsp0_res", rsp0_res, 10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_idle", busy, 0);
            check("t5_no_rsp1", rsp1_valid, 0);
        end
        check("t5_op_count", op_count, 1);

        // Counter wrap on the 2-bit instance.
        do_reset();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            set_req(k % 2, 5'b00000, k, 32'd1);
            @(negedge clk);
            check("t6_ready", (k % 2 == 1) ? req1_ready : req0_ready, 1);
            tick();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            wait_rsp(k % 2, 4, ok);
            if (ok) check("t6_res", (k % 2 == 1) ? rsp1_res : rsp0_res, k + 1);
        end
        @(negedge clk);
        check("t6_w_op_count", w_op_count, 1);
        check("t6_op_count", op_count, 5);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
